// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer stepped by a synchronised slow square wave.
// It supports a pedestrian request that shortens the current green phase.
`timescale 1ns/1ps
module traffic_light_ctrl #(
  parameter int unsigned GREEN_TICKS  = 20,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned PED_MIN      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_slow,
  input  logic       enable,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [7:0] countdown,
  output logic [2:0] phase,
  output logic       ped_pending,
  output logic       tick
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } state_t;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  logic       slow_meta, slow_sync, slow_prev;
  logic [1:0] sync_valid;
  logic       armed;
  logic       ped_meta, ped_sync, ped_prev;
  logic       ped_rise;
  logic       clamp;
  state_t     nxt;

  function automatic logic [7:0] duration(input logic [2:0] s);
    case (s)
      NS_GREEN, EW_GREEN:   duration = 8'(GREEN_TICKS);
      NS_YELLOW, EW_YELLOW: duration = 8'(YELLOW_TICKS);
      default:              duration = 8'(ALLRED_TICKS);
    endcase
  endfunction

  function automatic logic [2:0] ns_decode(input logic [2:0] s);
    case (s)
      NS_GREEN:  ns_decode = LIGHT_G;
      NS_YELLOW: ns_decode = LIGHT_Y;
      default:   ns_decode = LIGHT_R;
    endcase
  endfunction

  function automatic logic [2:0] ew_decode(input logic [2:0] s);
    case (s)
      EW_GREEN:  ew_decode = LIGHT_G;
      EW_YELLOW: ew_decode = LIGHT_Y;
      default:   ew_decode = LIGHT_R;
    endcase
  endfunction

  function automatic state_t next_phase(input logic [2:0] s);
    if (s == ALLRED_B) return NS_GREEN;
    return state_t'(s + 3'd1);
  endfunction

  // sync_valid marks when slow_sync holds a real post-reset sample, so a
  // clk_slow already high at reset release cannot arm the edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slow_meta  <= 1'b0;
      slow_sync  <= 1'b0;
      slow_prev  <= 1'b0;
      sync_valid <= 2'b00;
      armed      <= 1'b0;
      tick       <= 1'b0;
      ped_meta   <= 1'b0;
      ped_sync   <= 1'b0;
      ped_prev   <= 1'b0;
    end else begin
      slow_meta  <= clk_slow;
      slow_sync  <= slow_meta;
      slow_prev  <= slow_sync;
      sync_valid <= {sync_valid[0], 1'b1};
      if (sync_valid[1] && !slow_sync)
        armed <= 1'b1;
      tick       <= slow_sync & ~slow_prev & armed;
      ped_meta   <= ped_req;
      ped_sync   <= ped_meta;
      ped_prev   <= ped_sync;
    end
  end

  assign ped_rise = ped_sync & ~ped_prev;
  assign clamp    = ((phase == NS_GREEN) || (phase == EW_GREEN)) && ped_pending &&
                    (countdown > 8'(PED_MIN));
  assign nxt      = next_phase(phase);

  // The clamp outranks a same-cycle tick and ignores enable.
  // An all-red entry serves, and clears, any request pending at that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= NS_GREEN;
      countdown   <= 8'(GREEN_TICKS);
      ns_light    <= LIGHT_G;
      ew_light    <= LIGHT_R;
      ped_pending <= 1'b0;
    end else begin
      if (ped_rise)
        ped_pending <= 1'b1;
      if (phase > ALLRED_B) begin
        phase     <= NS_GREEN;
        countdown <= 8'(GREEN_TICKS);
        ns_light  <= LIGHT_G;
        ew_light  <= LIGHT_R;
      end else if (clamp) begin
        countdown <= 8'(PED_MIN);
      end else if (tick && enable) begin
        if (countdown == 8'd1) begin
          phase     <= nxt;
          countdown <= duration(nxt);
          ns_light  <= ns_decode(nxt);
          ew_light  <= ew_decode(nxt);
          if ((nxt == ALLRED_A) || (nxt == ALLRED_B))
            ped_pending <= 1'b0;
        end else begin
          countdown <= countdown - 8'd1;
        end
      end
    end
  end

endmodule
